zx81_mem_arbiter: RTL and testbench
===================================

Name: zx81_mem_arbiter

Overview:
- Shares the single-port synchronous 8-bit system RAM between two requesters.
  - The Z80 bus of the ZX81 core has priority.
  - A loader port (tape/ROM image loader, debug peek/poke) gets idle slots.
- A starvation counter guarantees the loader a slot by stretching the CPU cycle via cpu_wait.
- Sits between fpga_zx81's memory interface and the RAM block, all in the clk_sys domain.

Parameters:
AW, 16, address width of all address ports.
MAX_WAIT, 8, loader cycles waited (ld_req high, not granted) before a slot is stolen; legal range 1..255.
CW, 8, width of the starvation counter; must hold MAX_WAIT.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU access request; CPU holds it, with addr/we/wdata, while cpu_wait=1.
cpu_we  in  1  1=write, 0=read.
cpu_addr  in  AW  CPU address.
cpu_wdata  in  8  CPU write data.
cpu_wait  out  1  CPU request not serviced this cycle; hold request.
cpu_rvalid  out  1  pulse: cpu_rdata holds the read data.
cpu_rdata  out  8  CPU read data.
ld_req  in  1  loader request (valid).
ld_we  in  1  1=write, 0=read.
ld_addr  in  AW  loader address.
ld_wdata  in  8  loader write data.
ld_gnt  out  1  combinational ready; a transfer occurs when ld_req & ld_gnt.
ld_rvalid  out  1  pulse: ld_rdata holds the read data.
ld_rdata  out  8  loader read data.
mem_en  out  1  RAM access enable.
mem_we  out  1  RAM write enable.
mem_addr  out  AW  RAM address.
mem_wdata  out  8  RAM write data.
mem_rdata  in  8  RAM read data, valid 1 cycle after a read with mem_en=1.

Behaviour:
- At most one RAM access per cycle.
- The mem_* outputs are combinational muxes of the granted port. With no grant: mem_en=0, mem_we=0.
- Starvation counter wcnt (CW bits):
  - ld_req=1 & ld_gnt=0: wcnt increments, saturating at MAX_WAIT.
  - ld_gnt & ld_req, or ld_req=0: wcnt clears to 0.
- steal = (wcnt==MAX_WAIT) & ld_req.
- Grant rules, evaluated each cycle:
  - cpu_req & !steal: CPU granted; ld_gnt=0; cpu_wait=0.
  - steal: loader granted (ld_gnt=1). cpu_wait = cpu_req. The CPU is granted the next cycle, because wcnt is then 0.
  - !cpu_req: ld_gnt=1; the loader is granted if ld_req.
- No starvation of the CPU: after a steal, the CPU wins for at least MAX_WAIT consecutive cycles.
- Read return:
  - Registered tags cpu_rd_pend and ld_rd_pend are set in a cycle where that port is granted a read.
  - The corresponding rvalid output is driven by the tag in the following cycle.
  - Read latency is exactly 1 cycle from grant.
  - Writes produce no rvalid.
- Read data:
  - cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold.
  - cpu_hold captures mem_rdata when cpu_rvalid. ld_rdata/ld_hold work the same way.
  - Each port's data therefore stays stable until its next read.
- The loader may issue back-to-back transfers every granted cycle; reads pipeline.
- Simultaneous same-address CPU write and loader read: the CPU wins. The loader read executes in a later slot and sees the new data.
- Reset, asynchronous:
  - wcnt=0, cpu_rd_pend=0, ld_rd_pend=0, cpu_hold=8'h00, ld_hold=8'h00.
  - Outputs therefore read: cpu_rvalid=0, ld_rvalid=0, cpu_rdata=0, ld_rdata=0.
  - A read in flight when reset asserts is dropped; no rvalid follows.
- Combinational outputs during reset follow the grant rules with wcnt=0: a lone ld_req still sees ld_gnt=1. Requesters must be held idle during reset.

Test Plan:
- CPU only: read addr 16'h4000 (RAM preloaded 8'hA5) → mem_en=1 and cpu_wait=0 in the request cycle. cpu_rvalid=1 and cpu_rdata=8'hA5 the next cycle; ld_rvalid stays 0.
- Loader only, burst: 4 back-to-back reads 16'h0000..0003 → ld_gnt=1 every cycle. ld_rvalid high for 4 consecutive cycles starting 1 cycle after the first grant, with data in address order.
- Contention: cpu_req held high continuously with ld_req high, MAX_WAIT=8 → loader is blocked for cycles 0..7. In cycle 8, ld_gnt=1 and cpu_wait=1. In cycle 9 the CPU is granted and wcnt=0. The pattern repeats with a period of 9 cycles.
- Same cycle: CPU write 8'h3C to 16'h4010 with a loader read of 16'h4010 (wcnt<MAX_WAIT) → the CPU write goes first. The loader read is granted once cpu_req drops and returns 8'h3C.
- Reset mid-read: grant a CPU read, then assert reset in the next cycle before the clock edge → cpu_rvalid=0 immediately. No rvalid appears after release; cpu_rdata=8'h00.
- Loader abandons: ld_req high for 5 cycles without a grant, then low for 1 cycle → wcnt returns to 0. The next steal needs another 8 blocked cycles.

Source files
------------

// File: rtl/zx81_mem_arbiter.sv
// zx81_mem_arbiter: shares the single-port system RAM between the Z80 bus (priority)
// and a loader port, with a starvation counter that steals one slot for the loader.
module zx81_mem_arbiter #(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 8,
    parameter int CW       = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_wait,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [7:0]    ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          cpu_rd_pend_q, cpu_rd_pend_d, ld_rd_pend_q, ld_rd_pend_d;
    logic [7:0]    cpu_hold_q, cpu_hold_d, ld_hold_q, ld_hold_d;
    logic          steal, cpu_gnt, ld_go;
    always_comb begin
        steal         = ld_req && (wcnt_q == CW'(MAX_WAIT));
        cpu_gnt       = cpu_req && !steal;
        ld_gnt        = !cpu_gnt;
        ld_go         = ld_req && ld_gnt;
        cpu_wait      = cpu_req && steal;
        mem_en        = cpu_gnt || ld_go;
        mem_we        = cpu_gnt ? cpu_we : (ld_go && ld_we);
        mem_addr      = cpu_gnt ? cpu_addr : ld_addr;
        mem_wdata     = cpu_gnt ? cpu_wdata : ld_wdata;
        // a blocked loader counts up; any transfer or withdrawn request restarts the wait
        wcnt_d        = (ld_req && !ld_gnt) ? ((wcnt_q == CW'(MAX_WAIT)) ? wcnt_q : wcnt_q + CW'(1)) : '0;
        cpu_rd_pend_d = cpu_gnt && !cpu_we;
        ld_rd_pend_d  = ld_go && !ld_we;
        cpu_rvalid    = cpu_rd_pend_q;
        ld_rvalid     = ld_rd_pend_q;
        cpu_rdata     = cpu_rvalid ? mem_rdata : cpu_hold_q;
        ld_rdata      = ld_rvalid ? mem_rdata : ld_hold_q;
        cpu_hold_d    = cpu_rdata;
        ld_hold_d     = ld_rdata;
    end
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wcnt_q        <= '0;
            cpu_rd_pend_q <= 1'b0;
            ld_rd_pend_q  <= 1'b0;
            cpu_hold_q    <= 8'h00;
            ld_hold_q     <= 8'h00;
        end else begin
            wcnt_q        <= wcnt_d;
            cpu_rd_pend_q <= cpu_rd_pend_d;
            ld_rd_pend_q  <= ld_rd_pend_d;
            cpu_hold_q    <= cpu_hold_d;
            ld_hold_q     <= ld_hold_d;
        end
    end
endmodule

// File: tb/tb_zx81_mem_arbiter.sv
// tb_zx81_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (shadow memory, blocked-cycle count, expected read returns).
module tb_zx81_mem_arbiter;
    localparam int AW = 16;
    localparam int MAX_WAIT = 8;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
    logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
    logic [7:0] cpu_wdata = '0, ld_wdata = '0;
    logic cpu_wait, cpu_rvalid, ld_gnt, ld_rvalid, mem_en, mem_we;
    logic [7:0] cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0] ram [0:65535];
    logic [7:0] shadow [0:65535];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    zx81_mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT), .CW(8)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wait(cpu_wait), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk_sys) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic idle();
        cpu_req = 0; cpu_we = 0; ld_req = 0; ld_we = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        n_checks++;
        if (cpu_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid: cpu=%b ld=%b required 0 0", cpu_rvalid, ld_rvalid);
        end
        n_checks++;
        if (cpu_rdata !== 8'h00 || ld_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: cpu=%h ld=%h required 00 00", cpu_rdata, ld_rdata);
        end
        n_checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem: en=%b we=%b required 0 0", mem_en, mem_we);
        end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        ram[16'h4000] = 8'hA5;
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
        @(negedge clk_sys);
        n_checks++;
        if (mem_en !== 1'b1 || cpu_wait !== 1'b0 || mem_addr !== 16'h4000) begin
            n_fail++; $display("FAIL cpu_read_req: en=%b wait=%b addr=%h required 1 0 4000", mem_en, cpu_wait, mem_addr);
        end
        @(posedge clk_sys); #1;
        idle();
        @(negedge clk_sys);
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 || ld_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL cpu_read_ret: rvalid=%b rdata=%h ld_rvalid=%b required 1 a5 0", cpu_rvalid, cpu_rdata, ld_rvalid);
        end
        @(negedge clk_sys);
        n_checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL cpu_read_hold: rvalid=%b rdata=%h required 0 a5", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_ld_burst();
        logic [7:0] exp [0:3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) ram[i] = exp[i];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_sys); #1;
            ld_req = (i < 4); ld_we = 0; ld_addr = AW'(i);
            @(negedge clk_sys);
            if (i < 4) begin
                n_checks++;
                if (ld_gnt !== 1'b1) begin
                    n_fail++; $display("FAIL ld_burst_gnt[%0d]: %b required 1", i, ld_gnt);
                end
            end
            n_checks++;
            if (ld_rvalid !== (i >= 1 && i <= 4)) begin
                n_fail++; $display("FAIL ld_burst_rvalid[%0d]: %b required %b", i, ld_rvalid, (i >= 1 && i <= 4));
            end
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (ld_rdata !== exp[i-1]) begin
                    n_fail++; $display("FAIL ld_burst_data[%0d]: %h required %h", i, ld_rdata, exp[i-1]);
                end
            end
        end
        idle();
    endtask

    task automatic test_contention();
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4001;
        ld_req = 1; ld_we = 0; ld_addr = 16'h0005;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk_sys);
            n_checks++;
            if (ld_gnt !== (c % 9 == 8) || cpu_wait !== (c % 9 == 8)) begin
                n_fail++; $display("FAIL contention[%0d]: gnt=%b wait=%b required %b %b", c, ld_gnt, cpu_wait, (c % 9 == 8), (c % 9 == 8));
            end
            @(posedge clk_sys); #1;
        end
        idle();
        @(posedge clk_sys); #1;
    endtask

    task automatic test_same_addr();
        ram[16'h4010] = 8'h00;
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h4010; cpu_wdata = 8'h3C;
        ld_req = 1; ld_we = 0; ld_addr = 16'h4010;
        @(negedge clk_sys);
        n_checks++;
        if (ld_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 16'h4010 || mem_wdata !== 8'h3C) begin
            n_fail++; $display("FAIL same_addr_cpu: gnt=%b we=%b addr=%h wdata=%h required 0 1 4010 3c", ld_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk_sys); #1;
        cpu_req = 0;
        @(negedge clk_sys);
        n_checks++;
        if (ld_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL same_addr_ld: gnt=%b en=%b we=%b required 1 1 0", ld_gnt, mem_en, mem_we);
        end
        @(posedge clk_sys); #1;
        idle();
        @(negedge clk_sys);
        n_checks++;
        if (ld_rvalid !== 1'b1 || ld_rdata !== 8'h3C) begin
            n_fail++; $display("FAIL same_addr_ret: rvalid=%b rdata=%h required 1 3c", ld_rvalid, ld_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        ram[16'h4000] = 8'hA5;
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
        @(negedge clk_sys);
        idle();
        reset = 1'b1;
        #1;
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_read_now: rvalid=%b required 0", cpu_rvalid);
        end
        @(posedge clk_sys); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            n_checks++;
            if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
                n_fail++; $display("FAIL reset_mid_read[%0d]: rvalid=%b rdata=%h required 0 00", i, cpu_rvalid, cpu_rdata);
            end
        end
    endtask

    task automatic test_abandon();
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4002;
        for (int c = 0; c < 15; c++) begin
            ld_req = (c != 5); ld_we = 0; ld_addr = 16'h0007;
            @(negedge clk_sys);
            if (c != 5) begin
                n_checks++;
                if (ld_gnt !== (c == 14)) begin
                    n_fail++; $display("FAIL abandon[%0d]: gnt=%b required %b", c, ld_gnt, (c == 14));
                end
            end
            @(posedge clk_sys); #1;
        end
        idle();
    endtask

    task automatic test_random();
        int blocked = 0;
        logic p_cpu_rv = 0, p_ld_rv = 0, hold_cpu = 0, ld_done = 1;
        logic [7:0] p_cpu_d = 0, p_ld_d = 0, cpu_last = 0, ld_last = 0;
        logic steal, e_cpu_gnt, e_ld_gnt, e_wait;
        for (int a = 0; a < 8; a++) begin
            ram[16'h4000 + a] = 8'($urandom);
            shadow[16'h4000 + a] = ram[16'h4000 + a];
        end
        idle();
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_sys); #1;
            if (!hold_cpu) begin
                cpu_req = ($urandom_range(0, 99) < 70); cpu_we = 1'($urandom);
                cpu_addr = 16'h4000 + AW'($urandom_range(0, 7)); cpu_wdata = 8'($urandom);
            end
            if (ld_done || $urandom_range(0, 9) == 0) begin
                ld_req = ($urandom_range(0, 99) < 60); ld_we = 1'($urandom);
                ld_addr = 16'h4000 + AW'($urandom_range(0, 7)); ld_wdata = 8'($urandom);
            end
            steal = ld_req && (blocked == MAX_WAIT);
            e_cpu_gnt = cpu_req && !steal;
            e_ld_gnt = !cpu_req || steal;
            e_wait = cpu_req && steal;
            @(negedge clk_sys);
            n_checks++;
            if (cpu_rvalid !== p_cpu_rv || cpu_rdata !== (p_cpu_rv ? p_cpu_d : cpu_last)) begin
                n_fail++; $display("FAIL rand_cpu_ret[%0d]: rvalid=%b rdata=%h required %b %h", c, cpu_rvalid, cpu_rdata, p_cpu_rv, p_cpu_rv ? p_cpu_d : cpu_last);
            end
            n_checks++;
            if (ld_rvalid !== p_ld_rv || ld_rdata !== (p_ld_rv ? p_ld_d : ld_last)) begin
                n_fail++; $display("FAIL rand_ld_ret[%0d]: rvalid=%b rdata=%h required %b %h", c, ld_rvalid, ld_rdata, p_ld_rv, p_ld_rv ? p_ld_d : ld_last);
            end
            n_checks++;
            if (ld_gnt !== e_ld_gnt || cpu_wait !== e_wait || mem_en !== (e_cpu_gnt || (ld_req && e_ld_gnt))) begin
                n_fail++; $display("FAIL rand_grant[%0d]: gnt=%b wait=%b en=%b required %b %b %b", c, ld_gnt, cpu_wait, mem_en, e_ld_gnt, e_wait, e_cpu_gnt || (ld_req && e_ld_gnt));
            end
            if (p_cpu_rv) cpu_last = p_cpu_d;
            if (p_ld_rv) ld_last = p_ld_d;
            p_cpu_rv = e_cpu_gnt && !cpu_we;
            p_cpu_d = shadow[cpu_addr];
            if (e_cpu_gnt && cpu_we) shadow[cpu_addr] = cpu_wdata;
            p_ld_rv = ld_req && e_ld_gnt && !ld_we;
            p_ld_d = shadow[ld_addr];
            if (ld_req && e_ld_gnt && ld_we) shadow[ld_addr] = ld_wdata;
            blocked = (ld_req && !e_ld_gnt) ? ((blocked < MAX_WAIT) ? blocked + 1 : blocked) : 0;
            hold_cpu = e_wait;
            ld_done = !ld_req || e_ld_gnt;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ld_burst();
        test_contention();
        test_same_addr();
        test_reset_mid_read();
        test_abandon();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
